bpu_update_scheduler: RTL and testbench

// - Buffers resolved-branch outcomes from execute and issues them, one at a time, to the

---
 rtl/bpu_update_scheduler_if.sv | 33 +++
 rtl/bpu_update_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_bpu_update_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bpu_update_scheduler_if.sv
// Handshake bundle between execute/fetch/BPU and bpu_update_scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline.
interface bpu_update_scheduler_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  resolveValid;
  logic [ADDR_WIDTH-1:0] resolveAddr;
  logic                  resolveTaken;
  logic                  resolveReady;
  logic                  predictValid;
  logic [ADDR_WIDTH-1:0] predictAddr;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] updateAddr;
  logic                  branchTaken;
  logic                  update;
  logic [CNT_W-1:0]      pendingCount;
  logic                  dropErr;

  modport slave (
    input  resolveValid, resolveAddr, resolveTaken,
    input  predictValid, predictAddr, flush,
    output resolveReady, updateAddr, branchTaken, update, pendingCount, dropErr
  );

  modport master (
    output resolveValid, resolveAddr, resolveTaken,
    output predictValid, predictAddr, flush,
    input  resolveReady, updateAddr, branchTaken, update, pendingCount, dropErr
  );
endinterface

// File: rtl/bpu_update_scheduler.sv
// Queues resolved branches and issues them one per pulse to the predictor update port,
// spacing pulses by DELAY and deferring on fetch-address collisions. Optional stats: BPU_UPD_STATS_EN.
module bpu_update_scheduler #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int DELAY      = 0,
  parameter int MAX_DEFER  = 3
) (
  input  logic clk,
  input  logic rst,
  bpu_update_scheduler_if.slave bus
`ifdef BPU_UPD_STATS_EN
  ,
  output logic [15:0] issueCnt,
  output logic [15:0] deferCnt_total
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEF_W = $clog2(MAX_DEFER + 1);
  localparam int GAP_W = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [DEF_W-1:0] DEF_MAX  = DEF_W'(MAX_DEFER);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((DELAY > 0) ? DELAY - 1 : 0);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [DEPTH-1:0]      r_mem_taken;
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic [DEF_W-1:0]      r_defer;
  logic [GAP_W-1:0]      r_gap;
  state_t                r_state;
  logic                  r_update;
  logic [ADDR_WIDTH-1:0] r_upd_addr;
  logic                  r_upd_taken;
  logic                  r_drop_err;

  state_t                w_state_nxt;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_defer;
  logic                  w_head_vld;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic                  w_head_taken;
  logic                  w_collide;

  // No bypass: a full FIFO refuses a push even when it pops in the same cycle.
  assign w_ready      = (r_count != FULL_CNT);
  assign w_push       = bus.resolveValid && w_ready && !bus.flush;
  assign w_head_vld   = (r_count != '0);
  assign w_head_addr  = r_mem_addr[r_rptr];
  assign w_head_taken = r_mem_taken[r_rptr];
  assign w_collide    = bus.predictValid && (bus.predictAddr == w_head_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_defer     = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_head_vld) begin
            if (w_collide && (r_defer < DEF_MAX)) begin
              w_defer = 1'b1;
            end else begin
              w_pop = 1'b1;
              if (DELAY > 0) w_state_nxt = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // GAP dwells exactly DELAY cycles; the counter restarts on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gap <= '0;
    end else if ((r_state == S_GAP) && (w_state_nxt == S_GAP)) begin
      r_gap <= r_gap + 1'b1;
    end else begin
      r_gap <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wptr]  <= bus.resolveAddr;
      r_mem_taken[r_wptr] <= bus.resolveTaken;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_defer    <= '0;
      r_drop_err <= 1'b0;
    end else if (bus.flush) begin
      r_defer    <= '0;
      r_drop_err <= 1'b0;
    end else begin
      if (w_pop)        r_defer <= '0;
      else if (w_defer) r_defer <= r_defer + 1'b1;
      if (bus.resolveValid && !w_ready) r_drop_err <= 1'b1;
    end
  end

  // Issue stage: a pop in cycle C becomes the update pulse in cycle C+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_update    <= 1'b0;
      r_upd_addr  <= '0;
      r_upd_taken <= 1'b0;
    end else begin
      r_update <= w_pop;
      if (w_pop) begin
        r_upd_addr  <= w_head_addr;
        r_upd_taken <= w_head_taken;
      end
    end
  end

  assign bus.resolveReady = w_ready;
  assign bus.updateAddr   = r_upd_addr;
  assign bus.branchTaken  = r_upd_taken;
  assign bus.update       = r_update;
  assign bus.pendingCount = r_count;
  assign bus.dropErr      = r_drop_err;

`ifdef BPU_UPD_STATS_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_defer_total;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_cnt   <= '0;
      r_defer_total <= '0;
    end else begin
      if (r_update) r_issue_cnt   <= sat_inc16(r_issue_cnt);
      if (w_defer)  r_defer_total <= sat_inc16(r_defer_total);
    end
  end

  assign issueCnt       = r_issue_cnt;
  assign deferCnt_total = r_defer_total;
`endif

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Directed bench for bpu_update_scheduler: one DELAY=0 instance and one DELAY=2 instance.
`timescale 1ns/1ps
module tb_bpu_update_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bpu_update_scheduler_if #(.ADDR_WIDTH(6), .DEPTH(4)) u_if0 ();
  bpu_update_scheduler_if #(.ADDR_WIDTH(6), .DEPTH(4)) u_if2 ();

`ifdef BPU_UPD_STATS_EN
  logic [15:0] issue0, dtot0, issue2, dtot2;
`endif

  bpu_update_scheduler #(.ADDR_WIDTH(6), .DEPTH(4), .DELAY(0), .MAX_DEFER(3)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (u_if0)
`ifdef BPU_UPD_STATS_EN
    ,
    .issueCnt       (issue0),
    .deferCnt_total (dtot0)
`endif
  );

  bpu_update_scheduler #(.ADDR_WIDTH(6), .DEPTH(4), .DELAY(2), .MAX_DEFER(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2)
`ifdef BPU_UPD_STATS_EN
    ,
    .issueCnt       (issue2),
    .deferCnt_total (dtot2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if0.resolveValid = 1'b0; u_if0.resolveAddr = '0; u_if0.resolveTaken = 1'b0;
    u_if0.predictValid = 1'b0; u_if0.predictAddr = '0; u_if0.flush = 1'b0;
    u_if2.resolveValid = 1'b0; u_if2.resolveAddr = '0; u_if2.resolveTaken = 1'b0;
    u_if2.predictValid = 1'b0; u_if2.predictAddr = '0; u_if2.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++; if (u_if0.update !== 1'b0) begin errors++; $display("FAIL reset_update got %0b want 0", u_if0.update); end
    checks++; if (u_if0.pendingCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", u_if0.pendingCount); end
    checks++; if (u_if0.resolveReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", u_if0.resolveReady); end
    checks++; if (u_if0.dropErr !== 1'b0) begin errors++; $display("FAIL reset_drop got %0b want 0", u_if0.dropErr); end
    checks++; if (u_if0.updateAddr !== 6'd0 || u_if0.branchTaken !== 1'b0) begin errors++; $display("FAIL reset_outs got addr %0d taken %0b want 0 0", u_if0.updateAddr, u_if0.branchTaken); end
    checks++; if (u_if2.update !== 1'b0 || u_if2.pendingCount !== 3'd0) begin errors++; $display("FAIL reset_dut2 got upd %0b cnt %0d want 0 0", u_if2.update, u_if2.pendingCount); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_delay0();
    u_if0.resolveValid = 1'b1; u_if0.resolveAddr = 6'd5; u_if0.resolveTaken = 1'b1;
    tick();
    checks++; if (u_if0.pendingCount !== 3'd1 || u_if0.update !== 1'b0) begin errors++; $display("FAIL d0_push1 got cnt %0d upd %0b want 1 0", u_if0.pendingCount, u_if0.update); end
    u_if0.resolveAddr = 6'd9; u_if0.resolveTaken = 1'b0;
    tick();
    u_if0.resolveValid = 1'b0;
    checks++; if (u_if0.update !== 1'b1 || u_if0.updateAddr !== 6'd5 || u_if0.branchTaken !== 1'b1) begin errors++; $display("FAIL d0_pulse1 got upd %0b addr %0d tk %0b want 1 5 1", u_if0.update, u_if0.updateAddr, u_if0.branchTaken); end
    checks++; if (u_if0.pendingCount !== 3'd1) begin errors++; $display("FAIL d0_cnt_pushpop got %0d want 1", u_if0.pendingCount); end
    tick();
    checks++; if (u_if0.update !== 1'b1 || u_if0.updateAddr !== 6'd9 || u_if0.branchTaken !== 1'b0) begin errors++; $display("FAIL d0_pulse2 got upd %0b addr %0d tk %0b want 1 9 0", u_if0.update, u_if0.updateAddr, u_if0.branchTaken); end
    checks++; if (u_if0.pendingCount !== 3'd0) begin errors++; $display("FAIL d0_cnt_empty got %0d want 0", u_if0.pendingCount); end
    tick();
    checks++; if (u_if0.update !== 1'b0) begin errors++; $display("FAIL d0_pulse_end got %0b want 0", u_if0.update); end
`ifdef BPU_UPD_STATS_EN
    checks++; if (issue0 !== 16'd2 || dtot0 !== 16'd0) begin errors++; $display("FAIL d0_stats got issue %0d defer %0d want 2 0", issue0, dtot0); end
`endif
  endtask

  task automatic test_collision();
    u_if0.predictValid = 1'b1; u_if0.predictAddr = 6'd7;
    u_if0.resolveValid = 1'b1; u_if0.resolveAddr = 6'd7; u_if0.resolveTaken = 1'b1;
    tick();
    u_if0.resolveValid = 1'b0;
    checks++; if (u_if0.update !== 1'b0) begin errors++; $display("FAIL col_accept got upd %0b want 0", u_if0.update); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (u_if0.update !== 1'b0 || u_if0.pendingCount !== 3'd1) begin errors++; $display("FAIL col_defer%0d got upd %0b cnt %0d want 0 1", i, u_if0.update, u_if0.pendingCount); end
    end
    tick();
    checks++; if (u_if0.update !== 1'b1 || u_if0.updateAddr !== 6'd7 || u_if0.pendingCount !== 3'd0) begin errors++; $display("FAIL col_forced got upd %0b addr %0d cnt %0d want 1 7 0", u_if0.update, u_if0.updateAddr, u_if0.pendingCount); end
    u_if0.predictAddr = 6'd8;
    u_if0.resolveValid = 1'b1; u_if0.resolveAddr = 6'd7; u_if0.resolveTaken = 1'b0;
    tick();
    u_if0.resolveValid = 1'b0;
    tick();
    checks++; if (u_if0.update !== 1'b1 || u_if0.updateAddr !== 6'd7 || u_if0.branchTaken !== 1'b0) begin errors++; $display("FAIL col_nomatch got upd %0b addr %0d tk %0b want 1 7 0", u_if0.update, u_if0.updateAddr, u_if0.branchTaken); end
    u_if0.predictValid = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int pulses;
    u_if0.predictValid = 1'b1; u_if0.predictAddr = 6'd20;
    for (int i = 0; i < 4; i++) begin
      u_if0.resolveValid = 1'b1; u_if0.resolveAddr = 6'(20 + i); u_if0.resolveTaken = (i % 2 == 1);
      tick();
    end
    checks++; if (u_if0.resolveReady !== 1'b0 || u_if0.pendingCount !== 3'd4) begin errors++; $display("FAIL ovf_full got rdy %0b cnt %0d want 0 4", u_if0.resolveReady, u_if0.pendingCount); end
    checks++; if (u_if0.dropErr !== 1'b0) begin errors++; $display("FAIL ovf_nodrop got %0b want 0", u_if0.dropErr); end
    u_if0.resolveAddr = 6'd24; u_if0.resolveTaken = 1'b0;
    tick();
    u_if0.resolveValid = 1'b0;
    checks++; if (u_if0.dropErr !== 1'b1) begin errors++; $display("FAIL ovf_drop got %0b want 1", u_if0.dropErr); end
    checks++; if (u_if0.pendingCount !== 3'd3 || u_if0.update !== 1'b1 || u_if0.updateAddr !== 6'd20) begin errors++; $display("FAIL ovf_forcepop got cnt %0d upd %0b addr %0d want 3 1 20", u_if0.pendingCount, u_if0.update, u_if0.updateAddr); end
    u_if0.flush = 1'b1;
    tick();
    u_if0.flush = 1'b0;
    checks++; if (u_if0.pendingCount !== 3'd0 || u_if0.dropErr !== 1'b0) begin errors++; $display("FAIL ovf_flush got cnt %0d drop %0b want 0 0", u_if0.pendingCount, u_if0.dropErr); end
    checks++; if (u_if0.update !== 1'b0 || u_if0.resolveReady !== 1'b1) begin errors++; $display("FAIL ovf_flush_out got upd %0b rdy %0b want 0 1", u_if0.update, u_if0.resolveReady); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (u_if0.update === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL ovf_no_pulses got %0d want 0", pulses); end
    u_if0.predictValid = 1'b0;
  endtask

  task automatic test_flush_push();
    u_if0.flush = 1'b1;
    u_if0.resolveValid = 1'b1; u_if0.resolveAddr = 6'd30; u_if0.resolveTaken = 1'b1;
    tick();
    u_if0.flush = 1'b0; u_if0.resolveValid = 1'b0;
    checks++; if (u_if0.pendingCount !== 3'd0 || u_if0.update !== 1'b0) begin errors++; $display("FAIL fp_discard got cnt %0d upd %0b want 0 0", u_if0.pendingCount, u_if0.update); end
    tick();
    tick();
    checks++; if (u_if0.update !== 1'b0 || u_if0.pendingCount !== 3'd0) begin errors++; $display("FAIL fp_after got upd %0b cnt %0d want 0 0", u_if0.update, u_if0.pendingCount); end
  endtask

  task automatic test_back_to_back();
    int cyc [8];
    logic [5:0] adr [8];
    logic tkn [8];
    int n;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      u_if2.resolveValid = (k < 4);
      u_if2.resolveAddr  = 6'(10 + k);
      u_if2.resolveTaken = (k % 2 == 0);
      tick();
      if (u_if2.update === 1'b1 && n < 8) begin
        cyc[n] = k; adr[n] = u_if2.updateAddr; tkn[n] = u_if2.branchTaken; n++;
      end
    end
    u_if2.resolveValid = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", n); end
    for (int j = 0; j < 4 && j < n; j++) begin
      checks++; if (cyc[j] != 1 + 3 * j) begin errors++; $display("FAIL b2b_cycle%0d got %0d want %0d", j, cyc[j], 1 + 3 * j); end
      checks++; if (adr[j] !== 6'(10 + j) || tkn[j] !== (j % 2 == 0)) begin errors++; $display("FAIL b2b_data%0d got addr %0d tk %0b want %0d %0b", j, adr[j], tkn[j], 10 + j, (j % 2 == 0)); end
    end
    checks++; if (u_if2.pendingCount !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d want 0", u_if2.pendingCount); end
  endtask

  task automatic test_reset_midstream();
    u_if0.predictValid = 1'b1; u_if0.predictAddr = 6'd1;
    for (int i = 0; i < 3; i++) begin
      u_if0.resolveValid = 1'b1; u_if0.resolveAddr = 6'(1 + i); u_if0.resolveTaken = 1'b1;
      tick();
    end
    u_if0.resolveValid = 1'b0;
    checks++; if (u_if0.pendingCount !== 3'd3 || u_if0.update !== 1'b0) begin errors++; $display("FAIL mid_queued got cnt %0d upd %0b want 3 0", u_if0.pendingCount, u_if0.update); end
    rst = 1'b0;
    #1;
    checks++; if (u_if0.pendingCount !== 3'd0 || u_if0.resolveReady !== 1'b1) begin errors++; $display("FAIL mid_async got cnt %0d rdy %0b want 0 1", u_if0.pendingCount, u_if0.resolveReady); end
    tick();
    checks++; if (u_if0.update !== 1'b0 || u_if0.pendingCount !== 3'd0) begin errors++; $display("FAIL mid_next got upd %0b cnt %0d want 0 0", u_if0.update, u_if0.pendingCount); end
    checks++; if (u_if0.resolveReady !== 1'b1 || u_if0.dropErr !== 1'b0) begin errors++; $display("FAIL mid_flags got rdy %0b drop %0b want 1 0", u_if0.resolveReady, u_if0.dropErr); end
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (u_if0.update !== 1'b0) begin errors++; $display("FAIL mid_quiet got %0b want 0", u_if0.update); end
  endtask

  initial begin
    test_reset();
    test_delay0();
    test_collision();
    test_overflow();
    test_flush_push();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
